// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/control/result bundle between the control FSM (master) and seq_alu (slave)
interface seq_alu_if #(parameter int WIDTH = 8);
    logic             start;
    logic             alu_op;
    logic [2:0]       alu_ctrl;
    logic             flag_we;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             busy;
    logic             done;

    modport master (
        output start, alu_op, alu_ctrl, flag_we, src_a, src_b,
        input  result, flags, busy, done
    );

    modport slave (
        input  start, alu_op, alu_ctrl, flag_we, src_a, src_b,
        output result, flags, busy, done
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with {CO,OVF,N,Z} flags; SEQ_ALU_MUL_EN enables the iterative shift-add multiplier
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    seq_alu_if.slave   bus
);
    localparam int M = WIDTH - 1;

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] op_res;
    logic             op_co, op_ovf;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;

`ifdef SEQ_ALU_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic {IDLE, MUL} state_t;
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               fwe_q, fwe_d;
    logic [2*WIDTH-1:0] prod_q, prod_d, step;
`endif

    // single-cycle operation unit, evaluated on the live operands at the accept edge
    always_comb begin
        sum    = {1'b0, bus.src_a} + {1'b0, bus.src_b};
        diff   = {1'b0, bus.src_a} - {1'b0, bus.src_b};
        op_res = bus.src_b;
        op_co  = 1'b0;
        op_ovf = 1'b0;
        if (bus.alu_op) begin
            case (bus.alu_ctrl)
                3'b000: begin
                    op_res = sum[WIDTH-1:0];
                    op_co  = sum[WIDTH];
                    op_ovf = (bus.src_a[M] == bus.src_b[M]) && (sum[M] != bus.src_a[M]);
                end
                3'b001: begin
                    op_res = diff[WIDTH-1:0];
                    op_co  = !diff[WIDTH];
                    op_ovf = (bus.src_a[M] != bus.src_b[M]) && (diff[M] != bus.src_a[M]);
                end
                3'b010:  op_res = bus.src_a & bus.src_b;
                3'b011:  op_res = bus.src_a | bus.src_b;
                3'b100:  op_res = bus.src_a ^ bus.src_b;
                3'b111:  op_res = bus.src_b;
                default: op_res = '0;
            endcase
        end
    end

    // accept/complete control: single-cycle ops retire at the accept edge, MUL iterates WIDTH steps
    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
`ifdef SEQ_ALU_MUL_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        fwe_d   = fwe_q;
        prod_d  = prod_q;
        step    = prod_q + (b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0);
        if (state_q == IDLE) begin
            if (bus.start && bus.alu_op && bus.alu_ctrl == 3'b110) begin
                state_d = MUL;
                cnt_d   = '0;
                prod_d  = '0;
                a_d     = bus.src_a;
                b_d     = bus.src_b;
                fwe_d   = bus.flag_we;
            end else if (bus.start) begin
                result_d = op_res;
                flags_d  = bus.flag_we ? {op_co, op_ovf, op_res[M], ~|op_res} : flags_q;
                done_d   = 1'b1;
            end
        end else begin
            prod_d = step;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d  = IDLE;
                cnt_d    = '0;
                result_d = step[WIDTH-1:0];
                flags_d  = fwe_q ? {|step[2*WIDTH-1:WIDTH], 1'b0, step[M], ~|step[WIDTH-1:0]} : flags_q;
                done_d   = 1'b1;
            end
        end
`else
        if (bus.start) begin
            result_d = op_res;
            flags_d  = bus.flag_we ? {op_co, op_ovf, op_res[M], ~|op_res} : flags_q;
            done_d   = 1'b1;
        end
`endif
    end

    // state registers; reset aborts any in-flight multiply without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            fwe_q    <= 1'b0;
            prod_q   <= '0;
`endif
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
`ifdef SEQ_ALU_MUL_EN
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            fwe_q    <= fwe_d;
            prod_q   <= prod_d;
`endif
        end
    end

    assign bus.result = result_q;
    assign bus.flags  = flags_q;
    assign bus.done   = done_q;
`ifdef SEQ_ALU_MUL_EN
    assign bus.busy   = (state_q == MUL);
`else
    assign bus.busy   = 1'b0;
`endif
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vector table plus multi-cycle MUL/reset sequences for seq_alu (WIDTH=8)
module tb_seq_alu;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus();

    seq_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic         op;
        logic [2:0]   ctrl;
        logic         fwe;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   fl;
    } vec_t;

    vec_t v[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drives one start pulse; returns at the negedge following the accept edge
    task automatic apply(input logic op, input logic [2:0] ctrl, input logic fwe,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.alu_op   = op;
        bus.alu_ctrl = ctrl;
        bus.flag_we  = fwe;
        bus.src_a    = a;
        bus.src_b    = b;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    initial begin
        v[0]  = '{1'b1, 3'b000, 1'b1, 8'h7F, 8'h01, 8'h80, 4'b0110};
        v[1]  = '{1'b1, 3'b001, 1'b1, 8'h05, 8'h05, 8'h00, 4'b1001};
        v[2]  = '{1'b1, 3'b001, 1'b1, 8'h03, 8'h05, 8'hFE, 4'b0010};
        v[3]  = '{1'b1, 3'b010, 1'b0, 8'hF0, 8'h0F, 8'h00, 4'b0010};
        v[4]  = '{1'b0, 3'b000, 1'b0, 8'h11, 8'hA5, 8'hA5, 4'b0010};
        v[5]  = '{1'b0, 3'b001, 1'b1, 8'h11, 8'h00, 8'h00, 4'b0001};
        v[6]  = '{1'b1, 3'b000, 1'b1, 8'hFF, 8'h01, 8'h00, 4'b1001};
        v[7]  = '{1'b1, 3'b000, 1'b1, 8'h80, 8'h80, 8'h00, 4'b1101};
        v[8]  = '{1'b1, 3'b001, 1'b1, 8'h80, 8'h01, 8'h7F, 4'b1100};
        v[9]  = '{1'b1, 3'b011, 1'b1, 8'hA0, 8'h05, 8'hA5, 4'b0010};
        v[10] = '{1'b1, 3'b100, 1'b1, 8'hFF, 8'h0F, 8'hF0, 4'b0010};
        v[11] = '{1'b1, 3'b101, 1'b1, 8'h12, 8'h34, 8'h00, 4'b0001};
        v[12] = '{1'b1, 3'b111, 1'b1, 8'h12, 8'h81, 8'h81, 4'b0010};
        v[13] = '{1'b1, 3'b000, 1'b1, 8'h3C, 8'h0A, 8'h46, 4'b0000};

        bus.start = 1'b0; bus.alu_op = 1'b0; bus.alu_ctrl = 3'b000;
        bus.flag_we = 1'b0; bus.src_a = '0; bus.src_b = '0;
        repeat (2) @(negedge clk);
        check("reset_result", 32'(bus.result), 32'h0);
        check("reset_flags", 32'(bus.flags), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            apply(v[i].op, v[i].ctrl, v[i].fwe, v[i].a, v[i].b);
            check($sformatf("vec%0d_done", i), 32'(bus.done), 32'h1);
            check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'h0);
            check($sformatf("vec%0d_result", i), 32'(bus.result), 32'(v[i].res));
            check($sformatf("vec%0d_flags", i), 32'(bus.flags), 32'(v[i].fl));
            @(negedge clk);
            check($sformatf("vec%0d_done_drop", i), 32'(bus.done), 32'h0);
        end

`ifdef SEQ_ALU_MUL_EN
        apply(1'b1, 3'b110, 1'b1, 8'h10, 8'h20);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("mul_busy_c%0d", k), 32'(bus.busy), 32'h1);
            check($sformatf("mul_done_c%0d", k), 32'(bus.done), 32'h0);
            bus.start    = (k == 3);
            bus.alu_ctrl = 3'b000;
            bus.src_a    = 8'hFF;
            bus.src_b    = 8'hFF;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("mul1_done", 32'(bus.done), 32'h1);
        check("mul1_busy", 32'(bus.busy), 32'h0);
        check("mul1_result", 32'(bus.result), 32'h00);
        check("mul1_flags", 32'(bus.flags), 32'b1001);
        @(negedge clk);
        check("mul1_done_drop", 32'(bus.done), 32'h0);
        check("mul1_no_queued_op", 32'(bus.result), 32'h00);

        apply(1'b1, 3'b110, 1'b1, 8'h0F, 8'h0F);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_result", 32'(bus.result), 32'h0);
        check("abort_flags", 32'(bus.flags), 32'h0);
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_done", 32'(bus.done), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("abort_quiet_c%0d", k), 32'({bus.done, bus.busy}), 32'h0);
        end
        apply(1'b1, 3'b000, 1'b1, 8'h01, 8'h02);
        check("post_abort_done", 32'(bus.done), 32'h1);
        check("post_abort_result", 32'(bus.result), 32'h03);
        check("post_abort_flags", 32'(bus.flags), 32'b0000);
        apply(1'b1, 3'b110, 1'b1, 8'h03, 8'h05);
        repeat (7) @(negedge clk);
        check("mul2_busy_last", 32'(bus.busy), 32'h1);
        @(negedge clk);
        check("mul2_done", 32'(bus.done), 32'h1);
        check("mul2_result", 32'(bus.result), 32'h0F);
        check("mul2_flags", 32'(bus.flags), 32'b0000);
        apply(1'b1, 3'b110, 1'b0, 8'hFF, 8'hFF);
        repeat (8) @(negedge clk);
        check("mul3_done", 32'(bus.done), 32'h1);
        check("mul3_result", 32'(bus.result), 32'h01);
        check("mul3_flags_held", 32'(bus.flags), 32'b0000);
`else
        apply(1'b1, 3'b110, 1'b1, 8'h12, 8'h34);
        check("clr110_done", 32'(bus.done), 32'h1);
        check("clr110_busy", 32'(bus.busy), 32'h0);
        check("clr110_result", 32'(bus.result), 32'h00);
        check("clr110_flags", 32'(bus.flags), 32'b0001);
        @(negedge clk);
        check("clr110_done_drop", 32'(bus.done), 32'h0);
        check("clr110_busy_low", 32'(bus.busy), 32'h0);
        apply(1'b1, 3'b000, 1'b1, 8'h0F, 8'h01);
        check("after110_result", 32'(bus.result), 32'h10);
        check("after110_flags", 32'(bus.flags), 32'b0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
